rf_access_ctrl: RTL
===================

Name: rf_access_ctrl

Overview:
- Initiator side of the register-file read/write interface.
- Takes operand-fetch requests (two register addresses) from the control unit over a valid/ready handshake and drives the register file's read addresses.
- Waits out the register file's one-edge registered read latency, then returns both operands with read-after-write bypass applied.
- Passes writeback requests through to the register-file write port. Sits between the control unit / writeback stage and the register file.

Parameters:
DATA_W, 32, operand/write data width
ADDR_W, 4, register address width (16 registers)

Ports:
clk  in  1  system clock, all state on rising edge
rst_f  in  1  asynchronous active-low reset
op_valid  in  1  fetch request valid
op_ready  out  1  fetch request accepted when op_valid & op_ready at clock edge
op_ra  in  ADDR_W  source register A address
op_rb  in  ADDR_W  source register B address
res_valid  out  1  operands valid
res_ready  in  1  consumer takes operands
res_a  out  DATA_W  operand A
res_b  out  DATA_W  operand B
wb_valid  in  1  writeback request, always accepted
wb_reg  in  ADDR_W  writeback destination
wb_data  in  DATA_W  writeback data
read_rega  out  ADDR_W  to register file read address A
read_regb  out  ADDR_W  to register file read address B
rsa  in  DATA_W  from register file, latched A contents
rsb  in  DATA_W  from register file, latched B contents
write_reg  out  ADDR_W  to register file write address
write_data  out  DATA_W  to register file write data
rf_we  out  1  to register file write enable

Behaviour:
- Reset (rst_f low, asynchronous):
  - State IDLE.
  - read_rega, read_regb, res_a, res_b, and the bypass flags/data are all 0.
  - res_valid is 0.
  - rf_we is forced to 0 combinationally while rst_f is low.
  - An in-flight request is dropped with no response.
- Writeback path (combinational):
  - write_reg = wb_reg, write_data = wb_data.
  - rf_we = rst_f & wb_valid & (wb_reg != 0). Writes to R0 are discarded.
  - The write takes effect at the edge where it is presented.
- FSM states: IDLE, FETCH, LATCH, HOLD.
- IDLE: op_ready = 1. On accept, capture op_ra/op_rb into read_rega/read_regb, clear the bypass flags, go to FETCH.
- FETCH:
  - read_rega/b are stable; the register file latches rsa/rsb at the edge that exits FETCH.
  - At that edge, if rf_we & write_reg == read_rega: set byp_a, store wb_data. Same for B.
  - Next state is LATCH.
- LATCH:
  - rsa/rsb are valid this cycle.
  - At the exit edge, res_a = 0 if read_rega == 0; else wb_data if (rf_we & write_reg == read_rega) this cycle; else the stored bypass data if byp_a; else rsa. Same for B.
  - res_valid goes to 1; next state is HOLD.
- HOLD:
  - res_valid = 1; res_a/res_b are held as a snapshot. Later writebacks do not update them.
  - On res_ready: if op_valid, accept the new request (op_ready = res_ready in HOLD) and go to FETCH with res_valid cleared; else go to IDLE with res_valid cleared.
- Latency: accept edge E0 -> res_valid high after E2 (2 edges). Peak throughput is one request per 3 cycles.
- read_rega/read_regb hold their last captured values outside FETCH and change only on accept.
- op_ready is 0 in FETCH and LATCH, and in HOLD without res_ready.
- Simultaneous events:
  - A writeback and an accept in the same cycle are independent.
  - A write in the accept cycle (E0) lands before the register file's read at E1, so no bypass is needed.
  - If writes occur at both E1 and E2 to the same register, the E2 value wins.
- When ra == rb, both lanes bypass identically.

Decomposition:
- Package sisc_rf_pkg holds:
  - DATA_W/ADDR_W defaults
  - REG_ZERO constant
  - FSM state enum (IDLE, FETCH, LATCH, HOLD)
- Sub-module rf_bypass_lane is instantiated twice (A, B). It holds the byp flag/data register and the LATCH-edge select mux. Its inputs are the lane address, rf_we/write_reg/write_data, the register-file data, and the state strobes.

Test Plan:
- Reset mid-LATCH: req ra=3, rb=4; assert rst_f low in LATCH -> res_valid, read_rega, rf_we all 0 immediately; state IDLE; no response after release.
- Plain fetch: R3=0x11, R4=0x22 preloaded; req ra=3, rb=4 at E0 -> res_valid=1 after E2; res_a=0x11, res_b=0x22; op_ready=0 until res_ready.
- Bypass at E1: req ra=5 at E0; wb R5=0xAAAA5555 during FETCH -> res_a=0xAAAA5555, not the stale value 0.
- Bypass at E2, double write: wb R6=0x1 in FETCH and wb R6=0x2 in LATCH; req ra=rb=6 -> res_a=res_b=0x2.
- R0 handling: wb R0=0xFFFFFFFF (rf_we must stay 0); req ra=0, rb=0 -> res_a=res_b=0.
- Back-to-back with stall: hold res_ready=0 for 5 cycles, then pulse it with op_valid=1 -> exactly one accept at the res_ready edge; res_a unchanged during the stall despite a wb to the same register; the next result arrives 2 edges later.

Source files
------------

// File: rtl/sisc_rf_pkg.sv
// rtl/sisc_rf_pkg.sv - shared widths, zero-register id and FSM states for the register-file access controller
package sisc_rf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_t;
endpackage

// File: rtl/rf_access_ctrl_if.sv
// rtl/rf_access_ctrl_if.sv - operand-fetch request / operand response handshake bundle
interface rf_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              op_valid;
  logic              op_ready;
  logic [ADDR_W-1:0] op_ra;
  logic [ADDR_W-1:0] op_rb;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_a;
  logic [DATA_W-1:0] res_b;

  modport master (
    output op_valid, op_ra, op_rb, res_ready,
    input  op_ready, res_valid, res_a, res_b
  );

  modport slave (
    input  op_valid, op_ra, op_rb, res_ready,
    output op_ready, res_valid, res_a, res_b
  );
endinterface

// File: rtl/rf_access_ctrl_bypass_lane.sv
// rtl/rf_access_ctrl_bypass_lane.sv - one operand lane: FETCH-edge bypass capture and LATCH-edge source select
module rf_bypass_lane
  import sisc_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [ADDR_W-1:0] lane_addr,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] rs_data,
  input  logic              clr,
  input  logic              in_fetch,
  output logic [DATA_W-1:0] sel_data
);
  logic              byp;
  logic [DATA_W-1:0] byp_data;
  logic              hit;

  assign hit = rf_we && (write_reg == lane_addr);

  // A write landing on the read edge is missed by the register file, so keep it here.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      byp      <= 1'b0;
      byp_data <= '0;
    end else if (clr) begin
      byp      <= 1'b0;
    end else if (in_fetch && hit) begin
      byp      <= 1'b1;
      byp_data <= write_data;
    end
  end

  // Newest value wins: live write, then captured bypass, then register-file data.
  always_comb begin
    sel_data = rs_data;
    if (lane_addr == ADDR_W'(REG_ZERO)) sel_data = '0;
    else if (hit)                       sel_data = write_data;
    else if (byp)                       sel_data = byp_data;
  end
endmodule

// File: rtl/rf_access_ctrl.sv
// rtl/rf_access_ctrl.sv - register-file initiator: operand fetch with RAW bypass and writeback pass-through
module rf_access_ctrl
  import sisc_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_f,
  rf_access_ctrl_if.slave    cu,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [ADDR_W-1:0]  read_rega,
  output logic [ADDR_W-1:0]  read_regb,
  input  logic [DATA_W-1:0]  rsa,
  input  logic [DATA_W-1:0]  rsb,
  output logic [ADDR_W-1:0]  write_reg,
  output logic [DATA_W-1:0]  write_data,
  output logic               rf_we
);
  state_t            state, state_nxt;
  logic              accept;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [DATA_W-1:0] res_a_q, res_b_q;

  assign write_reg  = wb_reg;
  assign write_data = wb_data;
  assign rf_we      = rst_f & wb_valid & (wb_reg != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cu.op_ready  = 1'b0;
    cu.res_valid = 1'b0;
    case (state)
      IDLE: begin
        cu.op_ready = 1'b1;
        if (cu.op_valid) state_nxt = FETCH;
      end
      FETCH: state_nxt = LATCH;
      LATCH: state_nxt = HOLD;
      HOLD: begin
        cu.res_valid = 1'b1;
        cu.op_ready  = cu.res_ready;
        if (cu.res_ready) state_nxt = cu.op_valid ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = cu.op_valid & cu.op_ready;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      read_rega <= '0;
      read_regb <= '0;
      res_a_q   <= '0;
      res_b_q   <= '0;
    end else begin
      if (accept) begin
        read_rega <= cu.op_ra;
        read_regb <= cu.op_rb;
      end
      if (state == LATCH) begin
        res_a_q <= sel_a;
        res_b_q <= sel_b;
      end
    end
  end

  assign cu.res_a = res_a_q;
  assign cu.res_b = res_b_q;

  rf_bypass_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane_a (
    .clk        (clk),
    .rst_f      (rst_f),
    .lane_addr  (read_rega),
    .rf_we      (rf_we),
    .write_reg  (write_reg),
    .write_data (write_data),
    .rs_data    (rsa),
    .clr        (accept),
    .in_fetch   (state == FETCH),
    .sel_data   (sel_a)
  );

  rf_bypass_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane_b (
    .clk        (clk),
    .rst_f      (rst_f),
    .lane_addr  (read_regb),
    .rf_we      (rf_we),
    .write_reg  (write_reg),
    .write_data (write_data),
    .rs_data    (rsb),
    .clr        (accept),
    .in_fetch   (state == FETCH),
    .sel_data   (sel_b)
  );
endmodule
